// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic: Gray conversion helpers
// and the write-side FSM encoding.
package fifo_pkg;

  // Helpers work on a wide word; callers zero-extend and truncate to their own width.
  localparam int unsigned MaxW = 32;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StWrite = WRITE,
    StFull  = FULL
  } wstate_e;

  function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g);
    logic [MaxW-1:0] b;
    b[MaxW-1] = g[MaxW-1];
    for (int i = MaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for multi-bit Gray pointers crossing clock domains.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_write_logic.sv
// Write-domain control for the dual-clock FIFO: write pointer, Gray pointer export,
// synchronized full/almost-full/level flags and sticky overflow detection.
module fifo_write_logic
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_SZ    = 2,
  parameter int unsigned AFULL_THR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   rptr_gray,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [PTR_SZ:0]   wlevel,
  output logic              werr
);

  localparam int unsigned PW = PTR_SZ + 1;
  localparam logic [PTR_SZ:0] DepthL   = PW'(2 ** PTR_SZ);
  localparam logic [PTR_SZ:0] AfullLvl = PW'(2 ** PTR_SZ - AFULL_THR);

  logic [PTR_SZ:0]   wq2_rptr;
  logic [PTR_SZ:0]   wbin_q, wbin_d;
  logic [PTR_SZ:0]   wgray_q, wgray_d;
  logic [PTR_SZ:0]   wlevel_q, wlevel_d;
  logic [PTR_SZ-1:0] waddr_q;
  logic              wfull_q, wfull_d;
  logic              wafull_q, wafull_d;
  logic              werr_q, werr_d;
  wstate_e           state_q, state_d;

  // Full and level are derived only from the synchronized read pointer.
  sync_2ff #(
    .W (PW)
  ) u_sync_rptr (
    .clk (clk),
    .rst (rst),
    .d_i (rptr_gray),
    .q_o (wq2_rptr)
  );

  assign write_en = winc & ~wfull_q;

  always_comb begin
    wbin_d   = wbin_q + PW'(write_en);
    wgray_d  = PW'(bin2gray(MaxW'(wbin_d)));
    // Full when the pointers differ only in their top two Gray bits (one lap apart).
    wfull_d  = (wgray_d == {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]});
    wlevel_d = wbin_d - PW'(gray2bin(MaxW'(wq2_rptr)));
    wafull_d = (wlevel_d >= AfullLvl);
    werr_d   = werr_q | (winc & wfull_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wlevel_d == DepthL)  state_d = StFull;
        else if (wlevel_d != '0) state_d = StWrite;
      end
      StWrite: begin
        if (wlevel_d == DepthL)  state_d = StFull;
        else if (wlevel_d == '0) state_d = StIdle;
      end
      StFull: begin
        if (wlevel_d == '0)          state_d = StIdle;
        else if (wlevel_d != DepthL) state_d = StWrite;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q   <= '0;
      waddr_q  <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      werr_q   <= 1'b0;
      state_q  <= StIdle;
    end else begin
      wbin_q   <= wbin_d;
      waddr_q  <= wbin_d[PTR_SZ-1:0];
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
      werr_q   <= werr_d;
      state_q  <= state_d;
    end
  end

  assign waddr        = waddr_q;
  assign waddr_gray   = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign werr         = werr_q;

  a_full_matches_state : assert property (@(posedge clk) disable iff (rst)
    wfull_q == (state_q == StFull));

endmodule

// File: tb/tb_fifo_write_logic.sv
// Directed bench for fifo_write_logic (PTR_SZ=2, AFULL_THR=1) with a queue-based scoreboard.
module tb_fifo_write_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [2:0] rptr_gray;
  logic       write_en;
  logic [1:0] waddr;
  logic [2:0] waddr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [2:0] wlevel;
  logic       werr;

  fifo_write_logic #(
    .PTR_SZ    (2),
    .AFULL_THR (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .write_en     (write_en),
    .waddr        (waddr),
    .waddr_gray   (waddr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .werr         (werr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       wen;
    logic [1:0] addr;
    logic [2:0] gray;
    logic [2:0] lvl;
    logic       full;
    logic       afull;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
  endtask

  // Monitor: compares the DUT outputs against each queued expectation mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "write_en",     32'(write_en),     32'(e.wen));
      chk(e.nm, "waddr",        32'(waddr),        32'(e.addr));
      chk(e.nm, "waddr_gray",   32'(waddr_gray),   32'(e.gray));
      chk(e.nm, "wlevel",       32'(wlevel),       32'(e.lvl));
      chk(e.nm, "wfull",        32'(wfull),        32'(e.full));
      chk(e.nm, "walmost_full", 32'(walmost_full), 32'(e.afull));
      chk(e.nm, "werr",         32'(werr),         32'(e.err));
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [2:0] rp);
    @(posedge clk);
    #1;
    rst       = r;
    winc      = w;
    rptr_gray = rp;
  endtask

  task automatic push(input string nm, input logic wen, input logic [1:0] addr,
                      input logic [2:0] gray, input logic [2:0] lvl, input logic full,
                      input logic afull, input logic err);
    exp_t e;
    e.nm = nm; e.wen = wen; e.addr = addr; e.gray = gray; e.lvl = lvl;
    e.full = full; e.afull = afull; e.err = err;
    q.push_back(e);
  endtask

  // Wrap phase tables, index k = write number 1..9 (index 0 = start state).
  logic [2:0] gseq [10] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                            3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
  logic [2:0] rpseq[10] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b011,
                            3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [2:0] lvl_w[10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
  logic [2:0] lvl_i[10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};

  initial begin
    rst = 1'b1; winc = 1'b1; rptr_gray = 3'b000;

    cyc(1, 1, 3'b000); push("reset0", 1, 0, 3'b000, 0, 0, 0, 0);
    cyc(1, 1, 3'b000); push("reset1", 1, 0, 3'b000, 0, 0, 0, 0);

    cyc(0, 1, 3'b000); push("fill0", 1, 0, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b000); push("fill1", 1, 1, 3'b001, 1, 0, 0, 0);
    cyc(0, 1, 3'b000); push("fill2", 1, 2, 3'b011, 2, 0, 0, 0);
    cyc(0, 1, 3'b000); push("fill3", 1, 3, 3'b010, 3, 0, 1, 0);
    cyc(0, 1, 3'b000); push("ovf",   0, 0, 3'b110, 4, 1, 1, 0);
    cyc(0, 0, 3'b000); push("ovf_sticky", 0, 0, 3'b110, 4, 1, 1, 1);

    // Read pointer advances by one; must show up exactly after the 3rd edge.
    cyc(0, 0, 3'b001); push("drain_e0", 0, 0, 3'b110, 4, 1, 1, 1);
    cyc(0, 0, 3'b001); push("drain_e1", 0, 0, 3'b110, 4, 1, 1, 1);
    cyc(0, 0, 3'b001); push("drain_e2", 0, 0, 3'b110, 4, 1, 1, 1);
    cyc(0, 0, 3'b001); push("drain_e3", 0, 0, 3'b110, 3, 0, 1, 1);

    // Async reset between edges clears everything before the next edge.
    cyc(1, 0, 3'b000); push("rst_async", 0, 0, 3'b000, 0, 0, 0, 0);
    cyc(0, 0, 3'b000);

    for (int k = 1; k <= 9; k++) begin
      cyc(0, 1, rpseq[k-1]);
      push("wrap_w", 1, 2'((k - 1) % 4), gseq[k-1], lvl_w[k], 0, 0, 0);
      cyc(0, 0, rpseq[k]);
      push("wrap_i", 0, 2'(k % 4), gseq[k], lvl_i[k], 0, (lvl_i[k] >= 3'd3), 0);
      cyc(0, 0, rpseq[k]);
      cyc(0, 0, rpseq[k]);
    end

    cyc(0, 1, 3'b100); push("burst_w1", 1, 1, 3'b001, 2, 0, 0, 0);
    cyc(0, 1, 3'b100); push("burst_w2", 1, 2, 3'b011, 3, 0, 1, 0);
    cyc(1, 1, 3'b000); push("burst_rst", 1, 0, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b000); push("post_rst", 1, 0, 3'b000, 0, 0, 0, 0);
    cyc(0, 0, 3'b000); push("post_rst_w", 0, 1, 3'b001, 1, 0, 0, 0);
    cyc(0, 0, 3'b000);
    cyc(0, 0, 3'b000);

    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain_queue: got %0d pending, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_write_logic.md
Name: fifo_write_logic

Overview:
Write-domain control for the dual-clock FIFO. It is the producer-side counterpart to the read-side pointer/empty logic. It generates the binary write address and the Gray-coded write pointer for the read domain. It synchronizes the read domain's Gray pointer and derives the full, almost-full and fill-level flags, and flags overflow attempts.

Parameters:
PTR_SZ, 2, FIFO index width; DEPTH = 2**PTR_SZ; legal PTR_SZ >= 2
AFULL_THR, 1, walmost_full asserts when free slots <= AFULL_THR; legal 0 .. DEPTH-1

Ports:
clk  in  1  write-domain clock
rst  in  1  asynchronous, active-high reset
winc  in  1  write request from producer
rptr_gray  in  PTR_SZ+1  read pointer, Gray code, read clock domain (unsynchronized)
write_en  out  1  memory write strobe, = winc & ~wfull (combinational)
waddr  out  PTR_SZ  memory write address (registered)
waddr_gray  out  PTR_SZ+1  Gray write pointer to read domain (registered)
wfull  out  1  FIFO full (registered)
walmost_full  out  1  free slots <= AFULL_THR (registered)
wlevel  out  PTR_SZ+1  occupied entries as seen by write domain, 0..DEPTH (registered)
werr  out  1  sticky overflow flag

Behaviour:
- Reset (async, rst=1): all registers clear immediately, including the sync flops and the FSM (IDLE). Outputs are waddr=0, waddr_gray=0, wfull=0, walmost_full=0, wlevel=0, werr=0. write_en follows winc.
- Reset mid-burst: the in-flight write is abandoned and the pointers return to 0. The bench treats the FIFO as empty afterwards.
- Synchronizer: rptr_gray passes through 2 flops on clk to form wq2_rptr. A read-pointer change is reflected in wfull/wlevel on the 3rd rising clk edge after it becomes stable.
- Pointer: internal wbin[PTR_SZ:0].
  - Accepted write: winc=1 and wfull=0. The memory captures data at the current waddr on that edge, and wbin <= wbin+1, wrapping mod 2^(PTR_SZ+1).
  - waddr = wbin_next[PTR_SZ-1:0] registered, so waddr wraps mod DEPTH.
  - waddr_gray <= bin2gray(wbin_next), registered. Only one bit changes per accepted write.
- Full: wfull <= (bin2gray(wbin_next) == {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]}).
- Level: wlevel <= (wbin_next - gray2bin(wq2_rptr)) mod 2^(PTR_SZ+1).
- Almost full: walmost_full <= (level_next >= DEPTH-AFULL_THR).
- Overflow: winc=1 while wfull=1 gives write_en=0 and an unchanged pointer. werr is set on that edge and holds until reset.
- FSM (registered, next state computed from level_next):
  - IDLE: level 0. Goes to WRITE when level_next > 0.
  - WRITE: 0 < level < DEPTH. Goes to FULL when level_next == DEPTH, or to IDLE when level_next == 0.
  - FULL: goes to WRITE when level_next < DEPTH.
  - wfull must equal (state==FULL) at all times; this is checked as an assertion.
- Simultaneous write and read-pointer advance: the full/level decision uses only the synchronized pointer. The result is conservative: the FIFO never overflows, and wfull may deassert late by the sync latency.
- Never compute full from the unsynchronized rptr_gray.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parameterized by width
  - FSM state localparams IDLE=2'b00, WRITE=2'b01, FULL=2'b10
- Sub-module sync_2ff #(W): 2-flop synchronizer with async active-high reset to 0. It is reused by the read side for the write pointer.

Test Plan:
1. Reset: assert rst for 2 cycles with winc=1 -> waddr=0, waddr_gray=0, wfull=0, walmost_full=0, wlevel=0, werr=0. Release rst -> first accepted write is at waddr=0.
2. Fill (PTR_SZ=2, AFULL_THR=1, rptr_gray held 000): 4 consecutive winc cycles.
   - write_en is high 4 cycles with waddr 0,1,2,3.
   - waddr_gray goes 001,011,010,110.
   - wlevel goes 1,2,3,4.
   - walmost_full rises after the 3rd write; wfull rises after the 4th.
3. Overflow: a 5th winc while full -> write_en=0, waddr stays 0, waddr_gray stays 110, werr=1 and stays 1 after winc drops.
4. Drain visibility: from full, change rptr_gray 000->001 -> wfull falls and wlevel=3 exactly on the 3rd clk edge. walmost_full stays 1.
5. Wrap: 9 writes with rptr_gray tracking 2 entries behind -> wbin wraps 7->0 (waddr_gray 100->000), waddr sequence 0..3,0..3,0. wfull is never asserted and werr=0.
6. Async reset mid-burst: assert rst between clock edges during writes -> outputs clear before the next edge, and the FSM is IDLE after release.
